// File: rtl/alu_op_pkg.sv
// Shared constants and types for the MIPS ALU operation decoder.
// Opcode, funct and ALUControl encodings plus instruction field positions,
// used by the decoder, the ALU and their benches.
package alu_op_pkg;

    // Instruction field bit positions
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    // R-type / SPECIAL2 funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_MUL = 6'b000010;

    // ALUControl codes: R-type ops reuse funct, I-type ops reuse opcode
    localparam logic [5:0] ALU_ADD  = FN_ADD;
    localparam logic [5:0] ALU_SUB  = FN_SUB;
    localparam logic [5:0] ALU_AND  = FN_AND;
    localparam logic [5:0] ALU_OR   = FN_OR;
    localparam logic [5:0] ALU_XOR  = FN_XOR;
    localparam logic [5:0] ALU_NOR  = FN_NOR;
    localparam logic [5:0] ALU_SLT  = FN_SLT;
    localparam logic [5:0] ALU_SLL  = FN_SLL;
    localparam logic [5:0] ALU_SRL  = FN_SRL;
    localparam logic [5:0] ALU_ADDI = OP_ADDI;
    localparam logic [5:0] ALU_SLTI = OP_SLTI;
    localparam logic [5:0] ALU_ANDI = OP_ANDI;
    localparam logic [5:0] ALU_ORI  = OP_ORI;
    localparam logic [5:0] ALU_XORI = OP_XORI;
    localparam logic [5:0] ALU_MUL  = 6'b000011;
    localparam logic [5:0] ALU_NONE = 6'b000000;

    localparam logic [7:0] ILLEGAL_CNT_MAX = 8'hFF;

    // One decoded instruction
    typedef struct packed {
        logic [5:0]  alu_ctrl;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        reg_write;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Combinational decode of one MIPS instruction word into ALU control fields.
// Optional feature: define ALU_DEC_MUL_EN to accept SPECIAL2 mul.
module alu_op_decode_comb
    import alu_op_pkg::*;
(
    input  logic [31:0] instruction,
    output decode_t     decode
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        legal;

    assign opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
    assign funct    = instruction[FUNCT_MSB:FUNCT_LSB];
    assign rd       = instruction[RD_MSB:RD_LSB];
    assign imm_sext = {{16{instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};
    assign imm_zext = {16'h0000, instruction[IMM_MSB:IMM_LSB]};

    // Classify the instruction and build its ALU fields; illegal encodings stay all-zero.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        decode    = '0;
        legal     = 1'b0;
        decode.rs = instruction[RS_MSB:RS_LSB];
        decode.rt = instruction[RT_MSB:RT_LSB];
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                    FN_NOR, FN_SLT, FN_SLL, FN_SRL: begin
                        legal           = 1'b1;
                        decode.alu_ctrl = funct;
                        decode.dest     = rd;
                        decode.imm      = imm_sext;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                legal           = 1'b1;
                decode.alu_ctrl = opcode;
                decode.dest     = instruction[RT_MSB:RT_LSB];
                decode.imm      = imm_sext;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                legal           = 1'b1;
                decode.alu_ctrl = opcode;
                decode.dest     = instruction[RT_MSB:RT_LSB];
                decode.imm      = imm_zext;
            end
`ifdef ALU_DEC_MUL_EN
            OP_SPECIAL2: begin
                if (funct == FN_MUL) begin
                    legal           = 1'b1;
                    decode.alu_ctrl = ALU_MUL;
                    decode.dest     = rd;
                    decode.imm      = imm_sext;
                end
            end
`endif
            default: ;
        endcase
        decode.illegal   = !legal;
        decode.reg_write = legal && (decode.dest != 5'd0);
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered MIPS ALU-op decode stage with valid/ready handshake on both sides.
// Optional feature: define ALU_DEC_MUL_EN to accept SPECIAL2 mul.
module alu_op_decoder
    import alu_op_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instruction,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [5:0]  ALUControl,
    output logic [31:0] Immediate,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  DestReg,
    output logic        RegWrite,
    output logic        Illegal,
    output logic [7:0]  IllegalCnt
);

    decode_t    dec_next;
    decode_t    dec_q;
    logic       out_valid_q;
    logic [7:0] illegal_cnt_q;
    logic       transfer;

    alu_op_decode_comb u_decode (
        .instruction (Instruction),
        .decode      (dec_next)
    );

    assign InReady  = !out_valid_q || OutReady;
    assign transfer = InValid && InReady;

    // Pipeline register: flush wins, then a new transfer, then a drain by the consumer.
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (!Reset) begin
            out_valid_q   <= 1'b0;
            dec_q         <= '0;
            illegal_cnt_q <= '0;
        end else if (Flush) begin
            out_valid_q <= 1'b0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_next;
            if (dec_next.illegal && (illegal_cnt_q != ILLEGAL_CNT_MAX)) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
        end else if (OutReady) begin
            out_valid_q <= 1'b0;
        end
    end

    assign OutValid   = out_valid_q;
    assign ALUControl = dec_q.alu_ctrl;
    assign Immediate  = dec_q.imm;
    assign Rs         = dec_q.rs;
    assign Rt         = dec_q.rt;
    assign DestReg    = dec_q.dest;
    assign RegWrite   = dec_q.reg_write;
    assign Illegal    = dec_q.illegal;
    assign IllegalCnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed cases plus randomized
// traffic compared against a behavioural model of the decode rules.
// Honours ALU_DEC_MUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_op_decoder;

`ifdef ALU_DEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic        OutValid;
    logic        OutReady;
    logic [5:0]  ALUControl;
    logic [31:0] Immediate;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  DestReg;
    logic        RegWrite;
    logic        Illegal;
    logic [7:0]  IllegalCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [5:0]  m_alu;
    logic [31:0] m_imm;
    logic [4:0]  m_rs;
    logic [4:0]  m_rt;
    logic [4:0]  m_dst;
    logic        m_rw;
    logic        m_ill;
    int          m_cnt;

    alu_op_decoder dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Flush       (Flush),
        .InValid     (InValid),
        .InReady     (InReady),
        .Instruction (Instruction),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .ALUControl  (ALUControl),
        .Immediate   (Immediate),
        .Rs          (Rs),
        .Rt          (Rt),
        .DestReg     (DestReg),
        .RegWrite    (RegWrite),
        .Illegal     (Illegal),
        .IllegalCnt  (IllegalCnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decode rules written straight from the instruction-set table.
    task automatic model_decode(input logic [31:0] ins, output logic [5:0] alu,
                                output logic [31:0] imm, output logic [4:0] dst,
                                output logic rw, output logic ill);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sext;
        logic [31:0] zext;
        logic        legal;
        op    = ins[31:26];
        fn    = ins[5:0];
        zext  = ins & 32'h0000_FFFF;
        sext  = ins[15] ? (zext | 32'hFFFF_0000) : zext;
        legal = 1'b1;
        alu   = 6'd0;
        imm   = 32'd0;
        dst   = 5'd0;
        if (op == 6'd0 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02})) begin
            alu = fn; imm = sext; dst = ins[15:11];
        end else if (op inside {6'h08, 6'h0A}) begin
            alu = op; imm = sext; dst = ins[20:16];
        end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            alu = op; imm = zext; dst = ins[20:16];
        end else if (MUL_EN && op == 6'h1C && fn == 6'h02) begin
            alu = 6'd3; imm = sext; dst = ins[15:11];
        end else begin
            legal = 1'b0;
        end
        ill = !legal;
        rw  = legal && (dst != 5'd0);
    endtask

    task automatic model_reset();
        m_valid = 0; m_alu = 0; m_imm = 0; m_rs = 0; m_rt = 0;
        m_dst = 0; m_rw = 0; m_ill = 0; m_cnt = 0;
    endtask

    // One clock edge of the pipeline-stage behaviour.
    task automatic model_clock(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        if (fl) begin
            m_valid = 0;
        end else if (iv && (!m_valid || ordy)) begin
            model_decode(ins, m_alu, m_imm, m_dst, m_rw, m_ill);
            m_rs    = ins[25:21];
            m_rt    = ins[20:16];
            m_valid = 1;
            if (m_ill && m_cnt < 255) m_cnt++;
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, OutValid,   m_valid);
        check({tag, "_alu"},   ALUControl, m_alu);
        check({tag, "_imm"},   Immediate,  m_imm);
        check({tag, "_rs"},    Rs,         m_rs);
        check({tag, "_rt"},    Rt,         m_rt);
        check({tag, "_dst"},   DestReg,    m_dst);
        check({tag, "_rw"},    RegWrite,   m_rw);
        check({tag, "_ill"},   Illegal,    m_ill);
        check({tag, "_cnt"},   IllegalCnt, m_cnt[7:0]);
    endtask

    // Drive one cycle of inputs, check the handshake, clock, then check outputs.
    task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        InValid     = iv;
        Instruction = ins;
        OutReady    = ordy;
        Flush       = fl;
        #1;
        check({tag, "_inready"}, InReady, !m_valid || ordy);
        @(posedge Clk);
        model_clock(iv, ins, ordy, fl);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  rfn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
        logic [5:0]  iop [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r = {6'h00, r[25:6], rfn[$urandom_range(0, 8)]};
            1: r = {iop[$urandom_range(0, 4)], r[25:0]};
            2: r = {6'h1C, r[25:6], 6'h02};
            3: r = {6'h00, r[25:0]};
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[20:11] = 10'd0;
        return r;
    endfunction

    int cnt_before;

    initial begin
        Reset = 0; Flush = 0; InValid = 0; OutReady = 0; Instruction = 0;
        model_reset();
        @(posedge Clk);
        #1;
        check_outputs("reset");
        check("reset_inready", InReady, 1'b1);
        #2 Reset = 1;
        @(posedge Clk);
        #1;

        // add $8,$9,$10
        cycle("add", 1, 32'h012A4020, 1, 0);
        check("add_alu_c", ALUControl, 6'b100000);
        check("add_dst_c", DestReg, 5'd8);
        check("add_rw_c", RegWrite, 1'b1);
        check("add_valid_c", OutValid, 1'b1);

        // ori zero-extends, addi sign-extends
        cycle("ori", 1, 32'h3528FFFF, 1, 0);
        check("ori_imm_c", Immediate, 32'h0000FFFF);
        cycle("addi", 1, 32'h2128FFFF, 1, 0);
        check("addi_imm_c", Immediate, 32'hFFFFFFFF);
        check("addi_alu_c", ALUControl, 6'b001000);

        // sll $8,$9,5 then a 3-cycle consumer stall
        cycle("sll", 1, 32'h00094140, 1, 0);
        check("sll_alu_c", ALUControl, 6'b000000);
        check("sll_shamt_c", Immediate[10:6], 5'd5);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1, 32'h012A4020, 0, 0);
            check("stall_inready_c", InReady, 1'b0);
            check("stall_alu_c", ALUControl, 6'b000000);
            check("stall_imm_c", Immediate, 32'h00004140);
            check("stall_dst_c", DestReg, 5'd8);
        end
        cycle("drain", 0, 32'h0, 1, 0);

        // mul: legal only when the option is built in
        cnt_before = m_cnt;
        cycle("mul", 1, 32'h71095002, 1, 0);
        check("mul_alu_c", ALUControl, MUL_EN ? 6'b000011 : 6'b000000);
        check("mul_ill_c", Illegal, !MUL_EN);
        check("mul_cnt_c", IllegalCnt, MUL_EN ? cnt_before : cnt_before + 1);

        // Flush drops a same-cycle illegal transfer without counting it
        cycle("pre_flush", 1, 32'h012A4020, 1, 0);
        cnt_before = m_cnt;
        cycle("flush", 1, 32'hFC000000, 1, 1);
        check("flush_valid_c", OutValid, 1'b0);
        check("flush_cnt_c", IllegalCnt, cnt_before);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            cycle("sat", 1, 32'hFC000000, 1, 0);
        end
        check("sat_cnt_c", IllegalCnt, 8'd255);
        cycle("sat_flush", 1, 32'hFC000000, 1, 1);
        check("sat_flush_valid_c", OutValid, 1'b0);
        check("sat_flush_cnt_c", IllegalCnt, 8'd255);

        // Asynchronous reset while a decode is held
        cycle("pre_rst", 1, 32'h012A4020, 0, 0);
        check("pre_rst_valid_c", OutValid, 1'b1);
        InValid = 0;
        Reset   = 0;
        #1;
        model_reset();
        check_outputs("rst_async");
        check("rst_async_cnt_c", IllegalCnt, 8'd0);
        #2 Reset = 1;
        OutReady = 0;
        #1;
        check("rst_release_inready_c", InReady, 1'b1);
        cycle("post_rst", 1, 32'h2128FFFF, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
